hci_reorder_sequencer: RTL and testbench

- Command-driven sequencer that drives the NB_IN_CHAN-lane input side of the HCI reorder router.
- Splits one (base address, length in words, read/write) command into consecutive NB_IN_CHAN-word beats.
- For each beat it computes the bank rotation `order_o`, the beat address and the per-lane enables.
- Tracks the outstanding fixed-latency responses and signals completion. It sits between an accelerator streamer/controller and the router.

---
 rtl/hci_reorder_sequencer.sv | 141 ++++++++++++++
 tb/tb_hci_reorder_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_reorder_sequencer.sv
// Splits a (base address, length, read/write) command into NB_IN_CHAN-word beats for
// the HCI reorder router and counts the fixed-latency responses until the command completes.
module hci_reorder_sequencer #(
  parameter int NB_IN_CHAN  = 4,
  parameter int NB_OUT_CHAN = 8,
  parameter int LEN_W       = 16,
  parameter int WRITE_RESP  = 1,
  parameter int OUTST_W     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [31:0]                    cmd_addr_i,
  input  logic [LEN_W-1:0]               cmd_len_i,
  input  logic                           cmd_wen_i,
  output logic                           req_o,
  output logic [31:0]                    add_o,
  output logic                           wen_o,
  output logic [$clog2(NB_OUT_CHAN)-1:0] order_o,
  output logic [NB_IN_CHAN-1:0]          lane_en_o,
  input  logic                           gnt_i,
  input  logic                           r_valid_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int OW = $clog2(NB_OUT_CHAN);
  localparam logic [31:0]      STRIDE     = 32'(4 * NB_IN_CHAN);
  localparam logic [LEN_W-1:0] BEAT_WORDS = LEN_W'(NB_IN_CHAN);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state;
  logic [31:0]        addr;
  logic [LEN_W-1:0]   rem;
  logic [OUTST_W-1:0] outst;

  logic               inc;
  logic               dec;
  logic               err_set;
  logic [OUTST_W-1:0] outst_next;
  logic               last_beat;
  logic [LEN_W-1:0]   step;

  assign add_o     = addr;
  assign order_o   = addr[OW+1:2];
  assign last_beat = (rem <= BEAT_WORDS);
  assign step      = last_beat ? rem : BEAT_WORDS;

  always_comb begin
    lane_en_o = '0;
    for (int j = 0; j < NB_IN_CHAN; j++) begin
      lane_en_o[j] = (rem > LEN_W'(j));
    end
  end

  // Outstanding-response bookkeeping; both overflow and underflow saturate and flag an error.
  always_comb begin
    inc        = req_o & gnt_i & (wen_o | (WRITE_RESP != 0));
    dec        = r_valid_i;
    outst_next = outst;
    err_set    = 1'b0;
    if (inc && !dec) begin
      if (&outst) err_set = 1'b1;
      else        outst_next = outst + OUTST_W'(1);
    end else if (dec && !inc) begin
      if (outst == '0) err_set = 1'b1;
      else             outst_next = outst - OUTST_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      addr        <= '0;
      rem         <= '0;
      outst       <= '0;
      wen_o       <= 1'b0;
      req_o       <= 1'b0;
      busy_o      <= 1'b0;
      cmd_ready_o <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else if (clear_i) begin
      state       <= IDLE;
      addr        <= '0;
      rem         <= '0;
      outst       <= '0;
      req_o       <= 1'b0;
      busy_o      <= 1'b0;
      cmd_ready_o <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      outst  <= outst_next;
      if (err_set) err_o <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_len_i == '0) begin
              done_o <= 1'b1;
            end else begin
              addr        <= cmd_addr_i & ~32'h3;
              rem         <= cmd_len_i;
              wen_o       <= cmd_wen_i;
              state       <= ISSUE;
              req_o       <= 1'b1;
              busy_o      <= 1'b1;
              cmd_ready_o <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (gnt_i) begin
            addr <= addr + STRIDE;
            rem  <= rem - step;
            if (last_beat) begin
              state <= DRAIN;
              req_o <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Leave as soon as the response arriving this cycle retires the last outstanding beat.
          if (outst_next == '0) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            cmd_ready_o <= 1'b1;
            done_o      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hci_reorder_sequencer.sv
// Randomized bench for hci_reorder_sequencer: a queue-based beat-plan model predicts every
// output each cycle, with directed scenarios pinning literal values for model and DUT.
module tb_hci_reorder_sequencer;

  localparam int NB_IN      = 4;
  localparam int NB_OUT     = 8;
  localparam int LEN_W      = 16;
  localparam int WRITE_RESP = 1;
  localparam int OUTST_W    = 4;
  localparam int OUTST_MAX  = (1 << OUTST_W) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_DRAIN = 2;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  order;
    logic [3:0]  lane;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear, cmd_valid, cmd_wen, gnt, r_valid;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready, req, wen, busy, done, err;
  logic [31:0]      add;
  logic [2:0]       order;
  logic [3:0]       lane_en;

  logic             n_clear, n_cmd_valid, n_cmd_wen, n_gnt, n_r_valid;
  logic [31:0]      n_cmd_addr;
  logic [LEN_W-1:0] n_cmd_len;
  logic             n_cmd_ready, n_req, n_wen, n_busy, n_done, n_err;
  logic [31:0]      n_add;
  logic [2:0]       n_order;
  logic [3:0]       n_lane_en;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  beat_t plan[$];
  beat_t beats[$];
  int    m_phase;
  int    m_outst;
  bit    m_err, m_done, m_wen, resp_pending;

  logic        exp_req, exp_busy, exp_ready, exp_done, exp_err, exp_wen;
  logic [31:0] exp_add;
  logic [2:0]  exp_order;
  logic [3:0]  exp_lane;

  always #5 clk = ~clk;

  hci_reorder_sequencer #(
    .NB_IN_CHAN(NB_IN), .NB_OUT_CHAN(NB_OUT), .LEN_W(LEN_W),
    .WRITE_RESP(WRITE_RESP), .OUTST_W(OUTST_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_len_i(cmd_len), .cmd_wen_i(cmd_wen),
    .req_o(req), .add_o(add), .wen_o(wen), .order_o(order), .lane_en_o(lane_en),
    .gnt_i(gnt), .r_valid_i(r_valid),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  hci_reorder_sequencer #(
    .NB_IN_CHAN(NB_IN), .NB_OUT_CHAN(NB_OUT), .LEN_W(LEN_W),
    .WRITE_RESP(0), .OUTST_W(OUTST_W)
  ) dut_nw (
    .clk_i(clk), .rst_i(rst), .clear_i(n_clear),
    .cmd_valid_i(n_cmd_valid), .cmd_ready_o(n_cmd_ready), .cmd_addr_i(n_cmd_addr),
    .cmd_len_i(n_cmd_len), .cmd_wen_i(n_cmd_wen),
    .req_o(n_req), .add_o(n_add), .wen_o(n_wen), .order_o(n_order), .lane_en_o(n_lane_en),
    .gnt_i(n_gnt), .r_valid_i(n_r_valid),
    .busy_o(n_busy), .done_o(n_done), .err_o(n_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected beats of a command: word-aligned start, NB_IN words per beat, last beat partial.
  task automatic build_plan(input logic [31:0] a0, input int len);
    logic [31:0] a;
    int          left;
    beat_t       b;
    plan.delete();
    a    = a0 & 32'hFFFF_FFFC;
    left = len;
    while (left > 0) begin
      b.addr  = a;
      b.order = 3'((a >> 2) % NB_OUT);
      for (int j = 0; j < NB_IN; j++) b.lane[j] = (j < left);
      plan.push_back(b);
      a    = a + 32'(4 * NB_IN);
      left = left - ((left < NB_IN) ? left : NB_IN);
    end
  endtask

  task automatic update_exp();
    exp_req   = (m_phase == P_ISSUE);
    exp_busy  = (m_phase != P_IDLE);
    exp_ready = (m_phase == P_IDLE);
    exp_done  = m_done;
    exp_err   = m_err;
    exp_wen   = m_wen;
    exp_lane  = 4'h0;
    exp_add   = 32'h0;
    exp_order = 3'h0;
    if (exp_req) begin
      exp_lane  = beats[0].lane;
      exp_add   = beats[0].addr;
      exp_order = beats[0].order;
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    beats.delete();
    m_outst = 0;
    m_err = 0; m_done = 0; m_wen = 0; resp_pending = 0;
    update_exp();
  endtask

  // Advances the model by one clock using the inputs that were present at the edge.
  task automatic model_step();
    bit granted, counted;
    granted = (m_phase == P_ISSUE) && gnt;
    counted = granted && (m_wen || WRITE_RESP != 0);
    if (clear) begin
      m_phase = P_IDLE;
      beats.delete();
      m_outst = 0; m_err = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (counted && !r_valid) begin
        if (m_outst == OUTST_MAX) m_err = 1; else m_outst++;
      end else if (!counted && r_valid) begin
        if (m_outst == 0) m_err = 1; else m_outst--;
      end
      case (m_phase)
        P_IDLE: if (cmd_valid) begin
          if (cmd_len == 0) m_done = 1;
          else begin
            m_wen = cmd_wen;
            build_plan(cmd_addr, int'(cmd_len));
            beats   = plan;
            m_phase = P_ISSUE;
          end
        end
        P_ISSUE: if (gnt) begin
          beats.delete(0);
          if (beats.size() == 0) m_phase = P_DRAIN;
        end
        default: if (m_outst == 0) begin
          m_phase = P_IDLE;
          m_done  = 1;
        end
      endcase
    end
    resp_pending = counted;
    update_exp();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    r_valid = resp_pending;
  endtask

  task automatic settle();
    cmd_valid = 0; gnt = 1; clear = 0;
    for (int i = 0; i < 40 && m_phase != P_IDLE; i++) tick();
    tick();
    tick();
  endtask

  task automatic applyStimulus_clear_twice();
    cmd_valid = 0; clear = 1;
    tick();
    tick();
    clear = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_o", req, exp_req);
      check("busy_o", busy, exp_busy);
      check("cmd_ready_o", cmd_ready, exp_ready);
      check("done_o", done, exp_done);
      check("err_o", err, exp_err);
      check("lane_en_o", lane_en, exp_lane);
      if (exp_req) begin
        check("add_o", add, exp_add);
        check("order_o", order, exp_order);
        check("wen_o", wen, exp_wen);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nbeats;
    rst = 1; clear = 0; cmd_valid = 0; cmd_wen = 0; gnt = 0; r_valid = 0;
    cmd_addr = 0; cmd_len = 0;
    n_clear = 0; n_cmd_valid = 0; n_cmd_wen = 0; n_gnt = 0; n_r_valid = 0;
    n_cmd_addr = 0; n_cmd_len = 0;
    model_reset();
    chk_en = 1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", cmd_ready, 1);
    check("reset_req", req, 0);
    check("reset_busy", busy, 0);
    check("reset_add", add, 0);
    check("reset_lane", lane_en, 0);
    rst = 0;

    // Model pin: unaligned start and partial last beat.
    build_plan(32'h107, 6);
    check("plan_size", plan.size(), 2);
    check("plan0_addr", plan[0].addr, 32'h104);
    check("plan0_order", plan[0].order, 1);
    check("plan0_lane", plan[0].lane, 4'b1111);
    check("plan1_addr", plan[1].addr, 32'h114);
    check("plan1_order", plan[1].order, 5);
    check("plan1_lane", plan[1].lane, 4'b0011);

    // Scenario 1: read 0x100 len 8, grant always.
    cmd_valid = 1; cmd_addr = 32'h100; cmd_len = 8; cmd_wen = 1; gnt = 1;
    tick();
    cmd_valid = 0;
    check("s1_b1_add", add, 32'h100);
    check("s1_b1_order", order, 0);
    check("s1_b1_lane", lane_en, 4'hF);
    tick();
    check("s1_b2_add", add, 32'h110);
    check("s1_b2_order", order, 4);
    check("s1_b2_lane", lane_en, 4'hF);
    check("s1_b2_rvalid", r_valid, 1);
    tick();
    check("s1_drain_busy", busy, 1);
    check("s1_drain_done", done, 0);
    tick();
    check("s1_done", done, 1);
    check("s1_busy_drop", busy, 0);
    settle();

    // Scenario 2: read 0x107 len 6.
    cmd_valid = 1; cmd_addr = 32'h107; cmd_len = 6; cmd_wen = 1; gnt = 1;
    tick();
    cmd_valid = 0;
    check("s2_b1_add", add, 32'h104);
    check("s2_b1_order", order, 1);
    tick();
    check("s2_b2_add", add, 32'h114);
    check("s2_b2_order", order, 5);
    check("s2_b2_lane", lane_en, 4'b0011);
    settle();

    // Scenario 3: grant withheld for three cycles on the first beat.
    cmd_valid = 1; cmd_addr = 32'h100; cmd_len = 8; cmd_wen = 1; gnt = 0;
    tick();
    cmd_valid = 0;
    nbeats = 0;
    for (int i = 0; i < 4; i++) begin
      check("s3_hold_req", req, 1);
      check("s3_hold_add", add, 32'h100);
      check("s3_hold_order", order, 0);
      check("s3_hold_lane", lane_en, 4'hF);
      gnt = (i == 3);
      if (req && gnt) nbeats++;
      tick();
    end
    for (int i = 0; i < 20 && m_phase != P_IDLE; i++) begin
      if (req && gnt) nbeats++;
      tick();
    end
    check("s3_beats", nbeats, 2);
    settle();

    // Scenario 4: zero-length command completes without any request.
    cmd_valid = 1; cmd_addr = 32'h200; cmd_len = 0; cmd_wen = 1;
    tick();
    cmd_valid = 0;
    check("s4_done", done, 1);
    check("s4_req", req, 0);
    check("s4_busy", busy, 0);
    tick();
    check("s4_done_pulse", done, 0);

    // Scenario 5 on the WRITE_RESP=0 instance: uncounted write, then a read.
    n_cmd_valid = 1; n_cmd_wen = 0; n_cmd_addr = 32'h40; n_cmd_len = 4; n_gnt = 1;
    tick();
    n_cmd_valid = 0;
    check("s5_w_req", n_req, 1);
    check("s5_w_add", n_add, 32'h40);
    check("s5_w_lane", n_lane_en, 4'hF);
    check("s5_w_wen", n_wen, 0);
    tick();
    check("s5_drain_req", n_req, 0);
    check("s5_drain_busy", n_busy, 1);
    check("s5_drain_done", n_done, 0);
    tick();
    check("s5_w_done", n_done, 1);
    check("s5_w_busy", n_busy, 0);
    check("s5_w_ready", n_cmd_ready, 1);
    n_cmd_valid = 1; n_cmd_wen = 1; n_cmd_addr = 32'h80; n_cmd_len = 4;
    tick();
    n_cmd_valid = 0;
    check("s5_r_req", n_req, 1);
    check("s5_r_add", n_add, 32'h80);
    check("s5_r_wen", n_wen, 1);
    tick();
    n_r_valid = 1;
    check("s5_r_drain_busy", n_busy, 1);
    check("s5_r_drain_req", n_req, 0);
    tick();
    n_r_valid = 0;
    check("s5_r_done", n_done, 1);
    check("s5_err", n_err, 0);

    // Randomized traffic: stalls, clears, commands while busy, spurious responses, address wrap.
    for (int c = 0; c < 4000; c++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                              : 32'($urandom);
      cmd_len   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 19));
      cmd_wen   = 1'($urandom_range(0, 1));
      gnt       = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 79) == 0);
      if (m_phase == P_IDLE && $urandom_range(0, 29) == 0) r_valid = 1'b1;
      tick();
    end
    applyStimulus_clear_twice();
    settle();

    // Scenario 6: clear during beat 2, late response raises err, second clear removes it.
    cmd_valid = 1; cmd_addr = 32'h400; cmd_len = 16; cmd_wen = 1; gnt = 1;
    tick();
    cmd_valid = 0;
    tick();
    check("s6_b2_add", add, 32'h410);
    clear = 1;
    tick();
    clear = 0;
    check("s6_clr_req", req, 0);
    check("s6_clr_done", done, 0);
    check("s6_late_rvalid", r_valid, 1);
    tick();
    check("s6_err_set", err, 1);
    clear = 1;
    tick();
    clear = 0;
    check("s6_err_clr", err, 0);

    // Asynchronous reset in the middle of ISSUE.
    cmd_valid = 1; cmd_addr = 32'h500; cmd_len = 8; gnt = 0;
    tick();
    cmd_valid = 0;
    check("s6_issue_req", req, 1);
    #2;
    rst = 1;
    #1;
    check("s6_async_req", req, 0);
    check("s6_async_ready", cmd_ready, 1);
    model_reset();
    r_valid = 0;
    @(posedge clk);
    #1;
    rst = 0;

    cmd_valid = 1; cmd_addr = 32'h600; cmd_len = 5; cmd_wen = 1;
    tick();
    cmd_valid = 0;
    settle();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
